// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
// Holds the FSM state encoding, the PC step and the default reset PC.
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int          PC_INCR          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with clear, occupancy count and registered storage.
// Push and pop may happen together at full and at empty; a pop on empty is ignored.
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push at full is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_q[PTR_W-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[PTR_W-1:0]] <= data_i;
        wr_q <= wr_q + (PTR_W+1)'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + (PTR_W+1)'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i) begin
      assert (!(push_i && full && !do_pop));
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_buffer.sv
// fetch_buffer: issues in-order instruction reads and buffers {pc, word} for decode.
// Optional FETCH_BUFFER_STATS_EN adds saturating fetched/flushed counters.
`default_nettype none

module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_BUFFER_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    discard_q, discard_d;

  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic [CNT_W:0]           credit;
  logic                     issue;
  logic                     push;
  logic                     pop;

  always_comb begin
    credit     = {1'b0, fifo_count} + {1'b0, outst_q};
    issue      = (state_q == RUN) && enable && !redirect_valid &&
                 (credit < (CNT_W+1)'(DEPTH));
    push       = mem_rvalid && (discard_q == '0) && !redirect_valid;
    pop        = instr_valid && instr_ready;

    outst_d    = outst_q + CNT_W'(issue) - CNT_W'(mem_rvalid);

    // Every response still in flight at a redirect belongs to the old path.
    discard_d  = discard_q;
    if (redirect_valid) begin
      discard_d = outst_q - CNT_W'(mem_rvalid);
    end else if (mem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INCR);
    end

    // PC of the next kept response; discarded responses never advance it.
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      resp_pc_d = redirect_pc;
    end else if (push) begin
      resp_pc_d = resp_pc_q + ADDR_W'(PC_INCR);
    end

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid && (outst_d != '0)) begin
          state_d = DRAIN;
        end else if (!enable && (outst_q == '0)) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (discard_d == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (redirect_valid),
    .push_i  (push),
    .data_i  ({resp_pc_q, mem_rdata}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign mem_req     = issue;
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = !fifo_empty && !redirect_valid;
  assign instr_pc    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign instr_data  = fifo_head[DATA_W-1:0];

`ifdef FETCH_BUFFER_STATS_EN
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (pop && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
      if (redirect_valid && (flushed_q != '1)) flushed_q <= flushed_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed self-checking bench for fetch_buffer.
// Memory is a fixed-latency responder whose data word is derived from the address.
`default_nettype none

module tb_fetch_buffer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_BUFFER_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_flushed;
`endif

  int checks;
  int errors;
  int cyc;
  int lat;
  int reqs;

  logic        sched_v [32];
  logic [31:0] sched_a [32];

  fetch_buffer #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_BUFFER_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_flushed   (stat_flushed)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      sched_v[i] = 1'b0;
      sched_a[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    clear_mem();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic drive(input logic en, input logic redir, input logic [31:0] rpc, input logic rdy);
    enable = en; redirect_valid = redir; redirect_pc = rpc; instr_ready = rdy;
    mem_rvalid = sched_v[cyc % 32];
    mem_rdata  = mem_rvalid ? rd_word(sched_a[cyc % 32]) : 32'h0;
    sched_v[cyc % 32] = 1'b0;
    #1;
  endtask

  task automatic adv();
    if (mem_req) begin
      sched_v[(cyc + lat) % 32] = 1'b1;
      sched_a[(cyc + lat) % 32] = mem_addr;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  logic [31:0] exp_pc [5];

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1;

    // Reset state
    reset = 1'b0;
    enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    clear_mem();
    repeat (2) @(posedge clock);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_data", instr_data, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Streaming with latency 1
    do_reset(); lat = 1;
    drive(1, 0, 0, 1);
    check("t1_idle_no_req", mem_req, 0);
    adv();
    for (int k = 1; k <= 6; k++) begin
      drive(1, 0, 0, 1);
      check("t1_req", mem_req, 1);
      check("t1_addr", mem_addr, 32'(4 * (k - 1)));
      if (k >= 3) begin
        check("t1_valid", instr_valid, 1);
        check("t1_pc", instr_pc, 32'(4 * (k - 3)));
        check("t1_data", instr_data, rd_word(32'(4 * (k - 3))));
      end else begin
        check("t1_not_valid", instr_valid, 0);
      end
      adv();
    end
`ifdef FETCH_BUFFER_STATS_EN
    check("t1_stat_fetched", stat_fetched, 32'd4);
`endif

    // Backpressure: exactly DEPTH requests, then delivery in order
    do_reset(); lat = 1; reqs = 0;
    for (int c = 0; c <= 9; c++) begin
      drive(1, 0, 0, 0);
      if (mem_req) reqs++;
      if (c == 9) check("t2_req_stalled", mem_req, 0);
      adv();
    end
    check("t2_req_count", reqs, 4);
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    exp_pc[3] = 32'hC; exp_pc[4] = 32'h10;
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 1);
      check("t2_valid", instr_valid, 1);
      check("t2_pc", instr_pc, exp_pc[k]);
      if (k == 0) check("t2_full_no_req", mem_req, 0);
      if (k == 1) begin
        check("t2_resume_req", mem_req, 1);
        check("t2_resume_addr", mem_addr, 32'h10);
      end
      adv();
    end

    // Latency 3, redirect with 3 outstanding
    do_reset(); lat = 3;
    for (int c = 0; c <= 3; c++) begin
      drive(1, 0, 0, 1);
      if (c == 3) check("t3_addr_pre", mem_addr, 32'h8);
      adv();
    end
    drive(1, 1, 32'h100, 1);
    check("t3_redir_no_req", mem_req, 0);
    check("t3_redir_no_valid", instr_valid, 0);
    adv();
    for (int c = 5; c <= 6; c++) begin
      drive(1, 0, 0, 1);
      check("t3_drain_no_req", mem_req, 0);
      check("t3_drain_no_valid", instr_valid, 0);
      adv();
    end
    drive(1, 0, 0, 1);
    check("t3_first_req", mem_req, 1);
    check("t3_first_addr", mem_addr, 32'h100);
    adv();
    for (int c = 8; c <= 10; c++) begin
      drive(1, 0, 0, 1);
      check("t3_wait_valid", instr_valid, 0);
      adv();
    end
    drive(1, 0, 0, 1);
    check("t3_valid", instr_valid, 1);
    check("t3_pc", instr_pc, 32'h100);
    check("t3_data", instr_data, rd_word(32'h100));
    adv();

    // Redirect colliding with a handshake
    do_reset(); lat = 1;
    for (int c = 0; c <= 2; c++) begin
      drive(1, 0, 0, 1);
      adv();
    end
    drive(1, 1, 32'h200, 1);
    check("t4_void_valid", instr_valid, 0);
    check("t4_void_req", mem_req, 0);
    adv();
    drive(1, 0, 0, 1);
    check("t4_flushed", instr_valid, 0);
    check("t4_req", mem_req, 1);
    check("t4_addr", mem_addr, 32'h200);
`ifdef FETCH_BUFFER_STATS_EN
    check("t4_stat_flushed", stat_flushed, 32'd1);
`endif
    adv();
    drive(1, 0, 0, 1);
    check("t4_empty2", instr_valid, 0);
    adv();
    drive(1, 0, 0, 1);
    check("t4_valid", instr_valid, 1);
    check("t4_pc", instr_pc, 32'h200);
    adv();

    // PC wrap at the top of the address space
    do_reset(); lat = 1;
    drive(1, 1, 32'hFFFF_FFF8, 1);
    adv();
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 0, 1);
      if (k <= 3) check("t5_addr", mem_addr, exp_pc[k-1]);
      if (k >= 3) check("t5_pc", instr_pc, exp_pc[k-3]);
      adv();
    end

    // Asynchronous reset with two entries buffered
    do_reset(); lat = 1;
    for (int c = 0; c <= 3; c++) begin
      drive(1, 0, 0, 0);
      adv();
    end
    drive(1, 0, 0, 0);
    check("t6_pre_valid", instr_valid, 1);
    check("t6_pre_pc", instr_pc, 32'h0);
    #2;
    reset = 1'b0;
    clear_mem();
    #1;
    check("t6_mem_req", mem_req, 0);
    check("t6_mem_addr", mem_addr, 32'h0);
    check("t6_valid", instr_valid, 0);
    check("t6_data", instr_data, 32'h0);
    check("t6_pc", instr_pc, 32'h0);
`ifdef FETCH_BUFFER_STATS_EN
    check("t6_stat_fetched", stat_fetched, 32'h0);
    check("t6_stat_flushed", stat_flushed, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
